// File: rtl/covuniq_sink.sv
// Unique (adr,data) coverage sink: counters/bitmap/FSM update one edge after capture; event FIFO drops on full, no input backpressure.
// Define COVUNIQ_SINK_DUP_CNT_EN to build the repeat-transaction counter; otherwise dup_cnt is tied to 0.
module covuniq_sink #(
  parameter int ADR_W      = 2,
  parameter int DATA_W     = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd,
  input  logic [ADR_W-1:0]        adr,
  input  logic [DATA_W-1:0]       data,
  input  logic                    clear,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  output logic [ADR_W-1:0]        evt_adr,
  output logic [DATA_W-1:0]       evt_data,
  output logic [CNT_W-1:0]        total_cnt,
  output logic [ADR_W+DATA_W:0]   uniq_cnt,
  output logic [CNT_W-1:0]        dup_cnt,
  output logic                    all_seen,
  output logic                    overflow
);

  localparam int KEY_W = ADR_W + DATA_W;
  localparam int UNQ_W = KEY_W + 1;
  localparam int NPAIR = 1 << KEY_W;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [UNQ_W-1:0] NPAIR_C = UNQ_W'(NPAIR);
  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

  localparam logic [1:0] S_EMPTY    = 2'd0;
  localparam logic [1:0] S_COLLECT  = 2'd1;
  localparam logic [1:0] S_COMPLETE = 2'd2;

  logic             r_s1_vld;
  logic [KEY_W-1:0] r_s1_key;
  logic [NPAIR-1:0] r_bitmap;
  logic [CNT_W-1:0] r_total;
  logic [UNQ_W-1:0] r_uniq;
  logic [1:0]       r_state;
  logic             r_ovf;
  logic [KEY_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_cnt;

  logic             w_hit;
  logic             w_new;
  logic             w_pop;
  logic             w_full;
  logic             w_push;
  logic             w_drop;
  logic [UNQ_W-1:0] w_uniq_nxt;

  assign w_hit      = r_bitmap[r_s1_key];
  assign w_new      = r_s1_vld && !w_hit;
  assign w_pop      = (r_cnt != '0) && evt_ready;
  assign w_full     = (r_cnt == DEPTH_C);
  // A full FIFO still accepts the push when the head leaves in the same cycle.
  assign w_push     = w_new && (!w_full || w_pop);
  assign w_drop     = w_new && w_full && !w_pop;
  assign w_uniq_nxt = r_uniq + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_vld <= 1'b0;
      r_s1_key <= '0;
      r_bitmap <= '0;
      r_total  <= '0;
      r_uniq   <= '0;
      r_state  <= S_EMPTY;
      r_ovf    <= 1'b0;
    end else if (clear) begin
      r_s1_vld <= 1'b0;
      r_s1_key <= '0;
      r_bitmap <= '0;
      r_total  <= '0;
      r_uniq   <= '0;
      r_state  <= S_EMPTY;
      r_ovf    <= 1'b0;
    end else begin
      r_s1_vld <= cmd;
      r_s1_key <= {adr, data};
      if (r_s1_vld && (r_total != '1)) r_total <= r_total + 1'b1;
      if (w_new) begin
        r_bitmap[r_s1_key] <= 1'b1;
        r_uniq             <= w_uniq_nxt;
      end
      if (w_drop) r_ovf <= 1'b1;
      case (r_state)
        S_EMPTY:   if (w_new) r_state <= (w_uniq_nxt == NPAIR_C) ? S_COMPLETE : S_COLLECT;
        S_COLLECT: if (w_new && (w_uniq_nxt == NPAIR_C)) r_state <= S_COMPLETE;
        default:   r_state <= r_state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else if (clear) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= r_s1_key;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

`ifdef COVUNIQ_SINK_DUP_CNT_EN
  logic [CNT_W-1:0] r_dup;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dup <= '0;
    end else if (clear) begin
      r_dup <= '0;
    end else if (r_s1_vld && w_hit && (r_dup != '1)) begin
      r_dup <= r_dup + 1'b1;
    end
  end
  assign dup_cnt = r_dup;
`else
  assign dup_cnt = '0;
`endif

  assign evt_valid = (r_cnt != '0);
  assign evt_adr   = r_mem[r_rptr][KEY_W-1:DATA_W];
  assign evt_data  = r_mem[r_rptr][DATA_W-1:0];
  assign total_cnt = r_total;
  assign uniq_cnt  = r_uniq;
  assign all_seen  = (r_state == S_COMPLETE);
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_covuniq_sink.sv
// Bench for covuniq_sink: queue/array reference model checked every cycle, plus directed literal checks.
module tb_covuniq_sink;
  localparam int ADR_W = 2;
  localparam int DATA_W = 3;
  localparam int DEPTH = 4;
  localparam int CNT_W = 5;
  localparam int NPAIR = 32;
  localparam int TMAX = 31;

  logic       clk = 1'b0;
  logic       rst, cmd, clear, evt_ready;
  logic [1:0] adr;
  logic [2:0] data;
  logic       evt_valid, all_seen, overflow;
  logic [1:0] evt_adr;
  logic [2:0] evt_data;
  logic [4:0] total_cnt, dup_cnt;
  logic [5:0] uniq_cnt;

  int n_chk = 0;
  int n_bad = 0;

  covuniq_sink #(.ADR_W(ADR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cmd(cmd), .adr(adr), .data(data), .clear(clear),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_adr(evt_adr), .evt_data(evt_data),
    .total_cnt(total_cnt), .uniq_cnt(uniq_cnt), .dup_cnt(dup_cnt),
    .all_seen(all_seen), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a transaction seen at one edge takes effect at the next.
  logic       m_pend_v = 1'b0;
  logic [4:0] m_pend_k = '0;
  bit [31:0]  m_seen = '0;
  logic [4:0] m_q[$];
  int         m_total = 0, m_uniq = 0, m_dup = 0;
  bit         m_ovf = 1'b0;
  logic [4:0] pop_q[$];
  int         n_pop = 0;

  task automatic model_edge();
    if (rst || clear) begin
      m_pend_v = 1'b0;
      m_seen = '0;
      m_q.delete();
      m_total = 0; m_uniq = 0; m_dup = 0; m_ovf = 1'b0;
    end else begin
      if (m_q.size() != 0 && evt_ready) void'(m_q.pop_front());
      if (m_pend_v) begin
        if (m_total < TMAX) m_total++;
        if (!m_seen[m_pend_k]) begin
          m_seen[m_pend_k] = 1'b1;
          m_uniq++;
          if (m_q.size() < DEPTH) m_q.push_back(m_pend_k);
          else m_ovf = 1'b1;
        end else if (m_dup < TMAX) begin
          m_dup++;
        end
      end
      m_pend_v = cmd;
      m_pend_k = {adr, data};
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_edge();
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("evt_valid", evt_valid, m_q.size() != 0);
      if (m_q.size() != 0) chk("evt_head", {evt_adr, evt_data}, m_q[0]);
      chk("total_cnt", total_cnt, m_total);
      chk("uniq_cnt", uniq_cnt, m_uniq);
`ifdef COVUNIQ_SINK_DUP_CNT_EN
      chk("dup_cnt", dup_cnt, m_dup);
`else
      chk("dup_cnt", dup_cnt, 0);
`endif
      chk("all_seen", all_seen, m_uniq == NPAIR);
      chk("overflow", overflow, m_ovf);
      if (evt_valid && evt_ready) begin
        pop_q.push_back({evt_adr, evt_data});
        n_pop++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  logic [4:0] t3[6] = '{5'h00, 5'h01, 5'h0A, 5'h13, 5'h1C, 5'h1F};
  int perm[32];

  initial begin
    rst = 1'b1; cmd = 1'b0; adr = '0; data = '0; clear = 1'b0; evt_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_evt_valid", evt_valid, 0);
    chk("rst_evt_adr", evt_adr, 0);
    chk("rst_evt_data", evt_data, 0);
    chk("rst_total", total_cnt, 0);
    chk("rst_uniq", uniq_cnt, 0);
    chk("rst_all_seen", all_seen, 0);
    chk("rst_overflow", overflow, 0);
    rst = 1'b0;
    step();

    // Single transaction latency
    cmd = 1'b1; adr = 2'd1; data = 3'd5;
    step();
    cmd = 1'b0;
    step();
    chk("t1_total", total_cnt, 1);
    chk("t1_uniq", uniq_cnt, 1);
    chk("t1_evt_valid", evt_valid, 1);
    chk("t1_evt_adr", evt_adr, 1);
    chk("t1_evt_data", evt_data, 5);
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    chk("t1_popped", evt_valid, 0);

    // Back-to-back repeat of one pair
    do_clear();
    n_pop = 0;
    evt_ready = 1'b1;
    cmd = 1'b1; adr = 2'd2; data = 3'd3;
    repeat (3) step();
    cmd = 1'b0;
    repeat (3) step();
    chk("t2_total", total_cnt, 3);
    chk("t2_uniq", uniq_cnt, 1);
`ifdef COVUNIQ_SINK_DUP_CNT_EN
    chk("t2_dup", dup_cnt, 2);
`else
    chk("t2_dup", dup_cnt, 0);
`endif
    chk("t2_events", n_pop, 1);
    evt_ready = 1'b0;

    // Overflow with consumer stalled, then drain in order
    do_clear();
    pop_q.delete();
    for (int i = 0; i < 6; i++) begin
      cmd = 1'b1; {adr, data} = t3[i];
      step();
    end
    cmd = 1'b0;
    repeat (2) step();
    chk("t3_uniq", uniq_cnt, 6);
    chk("t3_overflow", overflow, 1);
    chk("t3_total", total_cnt, 6);
    evt_ready = 1'b1;
    repeat (8) step();
    evt_ready = 1'b0;
    chk("t3_events", pop_q.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < pop_q.size()) chk("t3_order", pop_q[i], t3[i]);
    chk("t3_overflow_sticky", overflow, 1);

    // Clear wins over a simultaneous capture
    clear = 1'b1; cmd = 1'b1; adr = 2'd0; data = 3'd7;
    step();
    clear = 1'b0; cmd = 1'b0;
    step();
    chk("t4_total", total_cnt, 0);
    chk("t4_uniq", uniq_cnt, 0);
    chk("t4_dup", dup_cnt, 0);
    chk("t4_evt_valid", evt_valid, 0);
    chk("t4_overflow", overflow, 0);
    cmd = 1'b1; adr = 2'd0; data = 3'd7;
    step();
    cmd = 1'b0;
    step();
    chk("t4_uniq_after", uniq_cnt, 1);
    chk("t4_evt_after", evt_valid, 1);

    // Full sweep of the pair space in random order
    do_clear();
    evt_ready = 1'b1;
    for (int i = 0; i < 32; i++) perm[i] = i;
    for (int i = 31; i > 0; i--) begin
      int j, t;
      j = $urandom_range(0, i);
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int i = 0; i < 32; i++) begin
      cmd = 1'b1; {adr, data} = 5'(perm[i]);
      step();
    end
    chk("t5_all_seen_early", all_seen, 0);
    chk("t5_uniq_31", uniq_cnt, 31);
    cmd = 1'b0;
    step();
    chk("t5_all_seen", all_seen, 1);
    chk("t5_uniq_32", uniq_cnt, 32);
    chk("t5_total_sat", total_cnt, 31);
    cmd = 1'b1; {adr, data} = 5'(perm[3]);
    step();
    cmd = 1'b0;
    step();
    chk("t5_total_hold", total_cnt, 31);
    chk("t5_all_seen_hold", all_seen, 1);
    evt_ready = 1'b0;

    // Asynchronous reset with a pair in flight
    cmd = 1'b1; adr = 2'd1; data = 3'd1;
    step();
    cmd = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t6_total", total_cnt, 0);
    chk("t6_uniq", uniq_cnt, 0);
    chk("t6_all_seen", all_seen, 0);
    chk("t6_evt_valid", evt_valid, 0);
    rst = 1'b0;
    repeat (2) step();
    chk("t6_total_after", total_cnt, 0);
    chk("t6_uniq_after", uniq_cnt, 0);
    chk("t6_evt_after", evt_valid, 0);

    // Randomized traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      cmd = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 3) == 0) {adr, data} = 5'($urandom_range(0, 3));
      else {adr, data} = 5'($urandom_range(0, 31));
      evt_ready = ((cyc / 64) % 4 == 1) ? 1'b0 : ($urandom_range(0, 3) != 0);
      clear = ($urandom_range(0, 499) == 0);
      step();
    end
    cmd = 1'b0; clear = 1'b0; evt_ready = 1'b1;
    repeat (8) step();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
